// File: rtl/melody_pkg.sv
// melody_pkg
// Shared types and constants for the melody sequencer.
//   seq_state_t : sequencer FSM states (IDLE, LOAD, PLAY, GAP)
//   note_t      : note-table entry layout {pitch, dur} for the default widths
//   REST        : pitch value that means "silence"
package melody_pkg;

  localparam int PITCH_W_DEF = 9;
  localparam int DUR_W_DEF   = 13;

  // A stored pitch of zero is a rest: the entry still takes time but stays silent.
  localparam int REST = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [PITCH_W_DEF-1:0] pitch;
    logic [DUR_W_DEF-1:0]   dur;
  } note_t;

endpackage

// File: rtl/note_ram.sv
// note_ram
// Note table storage: DEPTH words of WIDTH bits, synchronous write and
// registered read (data appears one clk after the address). No reset, so
// contents survive a sequencer reset.
//   clk     : system clock
//   we      : write strobe
//   wr_addr : write address
//   wr_data : word to store
//   rd_addr : read address
//   rd_data : registered read data
module note_ram #(
  parameter int WIDTH  = 22,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer
// Run-time programmable note sequencer. Steps through a writable table of
// {pitch maxval, duration in ticks}, drives the clkgen pitch and gates the DAC.
//   clk, reset       : system clock, synchronous active-high reset
//   tick_i           : one-clk timing strobe; durations count these
//   start_i, stop_i  : playback control pulses (stop has priority)
//   loop_i, len_i    : mode and sequence length, sampled at start
//   wr_en_i, wr_*_i  : table write port, honoured only while idle
//   pitch_o          : current pitch maxval, 0 when silent
//   note_on_o        : a non-rest note is sounding
//   note_start_o     : first cycle of each entry
//   busy_o           : sequencer is in LOAD/PLAY/GAP
//   done_o           : one-clk pulse when a one-shot sequence ends
module melody_sequencer
  import melody_pkg::*;
#(
  parameter  int PITCH_W   = PITCH_W_DEF,
  parameter  int DUR_W     = DUR_W_DEF,
  parameter  int NOTES     = 32,
  parameter  int GAP_TICKS = 0,
  localparam int ADDR_W    = $clog2(NOTES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_i,
  input  logic [ADDR_W:0]    len_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [PITCH_W-1:0] wr_pitch_i,
  input  logic [DUR_W-1:0]   wr_dur_i,
  output logic [PITCH_W-1:0] pitch_o,
  output logic               note_on_o,
  output logic               note_start_o,
  output logic               busy_o,
  output logic               done_o
);

  // gap_ctr counts 0..GAP_TICKS-1; keep at least one bit so the legato build still elaborates.
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
  localparam logic [DUR_W-1:0]   DUR_ONE    = DUR_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]    LEN_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]    NOTES_LEN  = (ADDR_W+1)'(NOTES);
  localparam logic [PITCH_W-1:0] REST_PITCH = PITCH_W'(REST);

  seq_state_t          state;
  seq_state_t          state_next;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   idx_next;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     len_next;
  logic                loop_r;
  logic                loop_next;
  logic [DUR_W-1:0]    dur_ctr;
  logic [DUR_W-1:0]    dur_ctr_next;
  logic [GAP_W-1:0]    gap_ctr;
  logic [GAP_W-1:0]    gap_ctr_next;
  logic                done_r;
  logic                done_next;
  logic                first_cycle;
  logic                advance;

  logic                ram_we;
  logic [PITCH_W+DUR_W-1:0] rd_data;
  logic [PITCH_W-1:0]  rd_pitch;
  logic [DUR_W-1:0]    rd_dur;
  logic [DUR_W-1:0]    dur_eff;
  logic [DUR_W-1:0]    dur_last;
  logic [ADDR_W:0]     len_last;
  logic                idx_is_last;
  logic                len_ok;

  // The table may only change while idle, so a playing entry never shifts under the FSM.
  assign ram_we = wr_en_i && (state == IDLE);

  // The read address is always idx: the LOAD cycle covers the one-clk read latency.
  note_ram #(
    .WIDTH  (PITCH_W + DUR_W),
    .DEPTH  (NOTES),
    .ADDR_W (ADDR_W)
  ) u_note_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_addr_i),
    .wr_data ({wr_pitch_i, wr_dur_i}),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  assign rd_pitch = rd_data[PITCH_W+DUR_W-1:DUR_W];
  assign rd_dur   = rd_data[DUR_W-1:0];

  // A stored duration of 0 plays as 1 tick; the end test is dur_ctr >= dur-1.
  assign dur_eff     = (rd_dur == '0) ? DUR_ONE : rd_dur;
  assign dur_last    = dur_eff - DUR_ONE;
  assign len_last    = len_r - LEN_ONE;
  assign idx_is_last = ({1'b0, idx} == len_last);
  assign len_ok      = (len_i != '0) && (len_i <= NOTES_LEN);

  assign busy_o = (state != IDLE);
  assign done_o = done_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      len_r       <= '0;
      loop_r      <= 1'b0;
      dur_ctr     <= '0;
      gap_ctr     <= '0;
      done_r      <= 1'b0;
      first_cycle <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      len_r       <= len_next;
      loop_r      <= loop_next;
      dur_ctr     <= dur_ctr_next;
      gap_ctr     <= gap_ctr_next;
      done_r      <= done_next;
      first_cycle <= (state == LOAD);
    end
  end

  // stop_i is checked before tick_i in every busy state so an abort always wins.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    len_next     = len_r;
    loop_next    = loop_r;
    dur_ctr_next = dur_ctr;
    gap_ctr_next = gap_ctr;
    done_next    = 1'b0;
    advance      = 1'b0;
    pitch_o      = '0;
    note_on_o    = 1'b0;
    note_start_o = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i && !stop_i && len_ok) begin
          state_next = LOAD;
          idx_next   = '0;
          len_next   = len_i;
          loop_next  = loop_i;
        end
      end
      LOAD: begin
        if (stop_i) begin
          state_next = IDLE;
        end else begin
          state_next   = PLAY;
          dur_ctr_next = '0;
        end
      end
      PLAY: begin
        pitch_o      = rd_pitch;
        note_on_o    = (rd_pitch != REST_PITCH);
        note_start_o = first_cycle;
        if (stop_i) begin
          state_next = IDLE;
        end else if (tick_i) begin
          if (dur_ctr >= dur_last) begin
            if (GAP_TICKS > 0) begin
              state_next   = GAP;
              gap_ctr_next = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_ctr_next = dur_ctr + DUR_ONE;
          end
        end
      end
      GAP: begin
        if (stop_i) begin
          state_next = IDLE;
        end else if (tick_i) begin
          if (gap_ctr >= GAP_LAST) begin
            advance = 1'b1;
          end else begin
            gap_ctr_next = gap_ctr + GAP_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Leaving an entry: wrap, finish, or fetch the next one.
    if (advance) begin
      if (idx_is_last) begin
        if (loop_r) begin
          idx_next   = '0;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end else begin
        idx_next   = idx + ADDR_ONE;
        state_next = LOAD;
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
// Self-checking bench for melody_sequencer. A legato instance and a
// GAP_TICKS=2 instance share all inputs; a monitor compares each played
// entry (pitch, note_on, ticks until the next entry, silent ticks) against a
// queue of expected entries pushed when playback is started.
module tb_melody_sequencer;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              tick_i;
  logic              start_i;
  logic              stop_i;
  logic              loop_i;
  logic [ADDR_W:0]   len_i;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [8:0]        wr_pitch_i;
  logic [12:0]       wr_dur_i;

  logic [8:0] pitch,   g_pitch;
  logic       note_on, g_note_on;
  logic       nstart,  g_nstart;
  logic       busy,    g_busy;
  logic       done,    g_done;

  melody_sequencer #(.PITCH_W(9), .DUR_W(13), .NOTES(32), .GAP_TICKS(0)) dut (
    .clk(clk), .reset(reset), .tick_i(tick_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .len_i(len_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_pitch_i(wr_pitch_i), .wr_dur_i(wr_dur_i), .pitch_o(pitch), .note_on_o(note_on),
    .note_start_o(nstart), .busy_o(busy), .done_o(done)
  );

  melody_sequencer #(.PITCH_W(9), .DUR_W(13), .NOTES(32), .GAP_TICKS(2)) dut_gap (
    .clk(clk), .reset(reset), .tick_i(tick_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .len_i(len_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_pitch_i(wr_pitch_i), .wr_dur_i(wr_dur_i), .pitch_o(g_pitch), .note_on_o(g_note_on),
    .note_start_o(g_nstart), .busy_o(g_busy), .done_o(g_done)
  );

  always #5 clk = ~clk;

  // Monitored instance select
  logic       mon_gap = 1'b0;
  logic [8:0] m_pitch;
  logic       m_on, m_start, m_busy, m_done;
  assign m_pitch = mon_gap ? g_pitch   : pitch;
  assign m_on    = mon_gap ? g_note_on : note_on;
  assign m_start = mon_gap ? g_nstart  : nstart;
  assign m_busy  = mon_gap ? g_busy    : busy;
  assign m_done  = mon_gap ? g_done    : done;

  typedef struct {
    int pitch;
    int on;
    int ticks;
    int silent;
  } exp_note_t;

  typedef struct {
    int   len;
    logic stop;
    int   exp_busy;
    int   exp_pitch;
    int   exp_start;
  } start_vec_t;

  exp_note_t exp_q[$];
  exp_note_t open_note;
  logic      note_open = 1'b0;
  int        cur_ticks = 0;
  int        cur_silent = 0;
  int        start_count = 0;
  int        done_count = 0;
  int        n_checks = 0;
  int        n_fail = 0;
  logic      ticks_en = 1'b0;
  int        tick_div = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Tick strobe every third clk while enabled
  initial begin
    tick_i = 1'b0;
    forever begin
      cyc();
      if (ticks_en) begin
        tick_div = (tick_div + 1) % 3;
        tick_i   = (tick_div == 0);
      end else begin
        tick_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor: an entry is closed by the next note_start or by done
  initial begin
    forever begin
      @(negedge clk);
      if (note_open && (m_start || m_done)) begin
        check_output("note_ticks", cur_ticks, open_note.ticks);
        check_output("silent_ticks", cur_silent, open_note.silent);
        note_open = 1'b0;
      end
      if (!m_busy) note_open = 1'b0;
      if (m_done) done_count++;
      if (m_start) begin
        start_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_note: got pitch %0d, expected no entry", m_pitch);
        end else begin
          open_note = exp_q.pop_front();
          check_output("entry_pitch", int'(m_pitch), open_note.pitch);
          check_output("entry_note_on", int'(m_on), open_note.on);
          note_open  = 1'b1;
          cur_ticks  = 0;
          cur_silent = 0;
        end
      end
      if (note_open && tick_i) begin
        cur_ticks++;
        if (m_pitch == 9'd0) cur_silent++;
      end
    end
  end

  task automatic push_note(input int p, input int on, input int t, input int s);
    exp_note_t e;
    e.pitch  = p;
    e.on     = on;
    e.ticks  = t;
    e.silent = s;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    wr_en_i = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    exp_q.delete();
    start_count = 0;
    done_count  = 0;
  endtask

  task automatic write_entry(input int addr, input int p, input int d);
    wr_en_i    = 1'b1;
    wr_addr_i  = ADDR_W'(addr);
    wr_pitch_i = 9'(p);
    wr_dur_i   = 13'(d);
    cyc();
    wr_en_i = 1'b0;
  endtask

  task automatic apply_stimulus(input int len, input logic lp, input logic stp);
    len_i   = (ADDR_W+1)'(len);
    loop_i  = lp;
    start_i = 1'b1;
    stop_i  = stp;
    cyc();
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic stop_pulse();
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      sample();
      n++;
    end while (m_busy && n < max_cyc);
    check_output("reach_idle", int'(m_busy), 0);
  endtask

  task automatic wait_starts(input int target, input int max_cyc);
    int n = 0;
    while (start_count < target && n < max_cyc) begin
      sample();
      n++;
    end
    check_output("note_start_wait", start_count, target);
  endtask

  start_vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 0,  stop: 1'b0, exp_busy: 0, exp_pitch: 0,   exp_start: 0};
    vecs[1] = '{len: 33, stop: 1'b0, exp_busy: 0, exp_pitch: 0,   exp_start: 0};
    vecs[2] = '{len: 63, stop: 1'b0, exp_busy: 0, exp_pitch: 0,   exp_start: 0};
    vecs[3] = '{len: 3,  stop: 1'b1, exp_busy: 0, exp_pitch: 0,   exp_start: 0};
    vecs[4] = '{len: 3,  stop: 1'b0, exp_busy: 1, exp_pitch: 266, exp_start: 1};
    vecs[5] = '{len: 32, stop: 1'b0, exp_busy: 1, exp_pitch: 266, exp_start: 1};
    vecs[6] = '{len: 1,  stop: 1'b0, exp_busy: 1, exp_pitch: 266, exp_start: 1};

    loop_i = 1'b0; len_i = '0; wr_addr_i = '0; wr_pitch_i = '0; wr_dur_i = '0;
    do_reset();

    // Reset state of both instances
    sample();
    check_output("rst_pitch", int'(pitch), 0);
    check_output("rst_note_on", int'(note_on), 0);
    check_output("rst_note_start", int'(nstart), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_gap_busy", int'(g_busy), 0);

    write_entry(0, 266, 4);
    write_entry(1, 199, 2);
    write_entry(2, 0, 3);

    // Start acceptance and N+1 / N+2 timing, ticks off
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_start != 0) push_note(266, 1, 0, 0);
      apply_stimulus(vecs[i].len, 1'b0, vecs[i].stop);
      sample();
      check_output($sformatf("vec%0d_busy", i), int'(busy), vecs[i].exp_busy);
      cyc();
      sample();
      check_output($sformatf("vec%0d_pitch", i), int'(pitch), vecs[i].exp_pitch);
      check_output($sformatf("vec%0d_note_start", i), int'(nstart), vecs[i].exp_start);
      cyc();
      stop_pulse();
      sample();
      check_output($sformatf("vec%0d_stopped", i), int'(busy), 0);
    end
    check_output("vec_queue_empty", exp_q.size(), 0);

    // One-shot playback with a second start while busy
    do_reset();
    ticks_en = 1'b1;
    push_note(266, 1, 4, 0);
    push_note(199, 1, 2, 0);
    push_note(0, 0, 3, 3);
    apply_stimulus(3, 1'b0, 1'b0);
    repeat (5) cyc();
    apply_stimulus(1, 1'b1, 1'b0);
    wait_idle(300);
    cyc();
    sample();
    check_output("oneshot_done_count", done_count, 1);
    check_output("oneshot_queue_empty", exp_q.size(), 0);
    check_output("oneshot_pitch_idle", int'(pitch), 0);

    // Loop mode: two full passes then the wrap back to entry 0
    do_reset();
    for (int p = 0; p < 2; p++) begin
      push_note(266, 1, 4, 0);
      push_note(199, 1, 2, 0);
      push_note(0, 0, 3, 3);
    end
    push_note(266, 1, 0, 0);
    apply_stimulus(3, 1'b1, 1'b0);
    wait_starts(7, 400);
    sample();
    check_output("loop_pitch_wrapped", int'(pitch), 266);
    cyc();
    stop_pulse();
    sample();
    check_output("loop_stopped", int'(busy), 0);
    check_output("loop_done_count", done_count, 0);
    check_output("loop_queue_empty", exp_q.size(), 0);

    // Stop during entry 1; a write while busy must be dropped
    do_reset();
    push_note(266, 1, 4, 0);
    push_note(199, 1, 0, 0);
    apply_stimulus(3, 1'b0, 1'b0);
    cyc();
    write_entry(0, 111, 7);
    wait_starts(2, 200);
    cyc();
    stop_pulse();
    sample();
    check_output("stop_busy", int'(busy), 0);
    check_output("stop_pitch", int'(pitch), 0);
    check_output("stop_note_on", int'(note_on), 0);
    repeat (3) cyc();
    check_output("stop_no_done", done_count, 0);
    push_note(266, 1, 4, 0);
    apply_stimulus(1, 1'b0, 1'b0);
    wait_idle(200);
    cyc();
    check_output("retained_done_count", done_count, 1);
    check_output("retained_queue_empty", exp_q.size(), 0);

    // Reset mid-play, then replay the retained table
    do_reset();
    push_note(266, 1, 0, 0);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_starts(1, 100);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sample();
    check_output("midreset_busy", int'(busy), 0);
    check_output("midreset_pitch", int'(pitch), 0);
    done_count = 0;
    push_note(266, 1, 4, 0);
    push_note(199, 1, 2, 0);
    push_note(0, 0, 3, 3);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_idle(300);
    cyc();
    check_output("replay_done_count", done_count, 1);
    check_output("replay_queue_empty", exp_q.size(), 0);

    // Duration 0 plays for a single tick
    do_reset();
    write_entry(3, 150, 0);
    write_entry(4, 321, 2);
    write_entry(0, 150, 0);
    write_entry(1, 321, 2);
    push_note(150, 1, 1, 0);
    push_note(321, 1, 2, 0);
    apply_stimulus(2, 1'b0, 1'b0);
    wait_idle(200);
    cyc();
    check_output("dur0_done_count", done_count, 1);
    check_output("dur0_queue_empty", exp_q.size(), 0);

    // Articulation gap instance: 3 sounding ticks then 2 silent ones per entry
    do_reset();
    mon_gap = 1'b1;
    write_entry(0, 177, 3);
    write_entry(1, 177, 3);
    push_note(177, 1, 5, 2);
    push_note(177, 1, 5, 2);
    apply_stimulus(2, 1'b0, 1'b0);
    wait_idle(300);
    cyc();
    check_output("gap_done_count", done_count, 1);
    check_output("gap_queue_empty", exp_q.size(), 0);
    check_output("gap_pitch_idle", int'(g_pitch), 0);

    ticks_en = 1'b0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
